// File: rtl/uart_rx_oversampler.sv
// 16x oversampling UART receiver with 3-sample majority vote, framing-error and line-break handling.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_oversampler #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_pulse,
    input  logic                 rx,
    output logic                 uart_rx_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_err,
    output logic                 rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic [1:0]             samp_q;
    logic                   bit_val_q;
    logic                   vote;

    logic tick_clr, bit_clr, shift_en, load_data, done_set, err_set;
`ifdef UART_RX_PARITY_EN
    logic par_cap, par_bad_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Third sample is taken live at tick 9 so START/STOP can decide without waiting a tick.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        tick_clr  = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        load_data = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap   = 1'b0;
`endif
        if (baud_pulse) begin
            case (state)
                IDLE: begin
                    tick_clr = 1'b1;
                    if (!rx_s) state_n = START;
                end
                START: begin
                    if (tick_cnt == 4'd9 && vote) begin
                        state_n = IDLE;
                    end else if (tick_cnt == 4'd15) begin
                        state_n = DATA;
                        bit_clr = 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == 4'd15) begin
                        shift_en = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == 4'd15) begin
                        par_cap = 1'b1;
                        state_n = STOP;
                    end
                end
`endif
                STOP: begin
                    // Decide at mid-bit so a following start bit is never missed.
                    if (tick_cnt == 4'd9) begin
                        if (vote) begin
                            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                err_set = 1'b1;
                            end else begin
                                done_set  = 1'b1;
                                load_data = 1'b1;
                            end
`else
                            done_set  = 1'b1;
                            load_data = 1'b1;
`endif
                        end else begin
                            err_set = 1'b1;
                            state_n = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            samp_q    <= '0;
            bit_val_q <= 1'b0;
        end else if (baud_pulse) begin
            tick_cnt <= tick_clr ? 4'd0 : tick_cnt + 4'd1;
            if (bit_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (tick_cnt == 4'd7) samp_q[0] <= rx_s;
            if (tick_cnt == 4'd8) samp_q[1] <= rx_s;
            if (tick_cnt == 4'd9) bit_val_q <= vote;
            if (shift_en) shift_q <= {bit_val_q, shift_q[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)          par_bad_q <= 1'b0;
        else if (par_cap) par_bad_q <= (^shift_q) ^ bit_val_q;
    end
`endif

    // Strobes are only raised on baud ticks, so registering them gives one-clk pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_rx_done <= 1'b0;
            frame_err    <= 1'b0;
            rx_data      <= '0;
        end else begin
            uart_rx_done <= done_set;
            frame_err    <= err_set;
            if (load_data) rx_data <= shift_q;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Table-driven bench for uart_rx_oversampler plus hand-written glitch, break, reset and back-to-back sequences.
// Build with UART_RX_PARITY_EN defined to also exercise the parity bit.
module tb_uart_rx_oversampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse;
    logic       rx;
    logic       uart_rx_done;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       rx_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int baud_div = 4;
    int baud_cnt = 0;
    logic [7:0] done_log[$];
    logic [7:0] model_rx;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         spike_bit;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[$];

    uart_rx_oversampler #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_pulse   (baud_pulse),
        .rx           (rx),
        .uart_rx_done (uart_rx_done),
        .rx_data      (rx_data),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        baud_pulse = 1'b0;
        forever begin
            @(negedge clk);
            baud_cnt   = (baud_cnt + 1) % baud_div;
            baud_pulse = (baud_cnt == 0);
        end
    end

    always @(negedge clk) begin
        if (uart_rx_done) begin
            done_cnt++;
            done_log.push_back(rx_data);
        end
        if (frame_err) err_cnt++;
        if (uart_rx_done && frame_err) checkOutput("pulse_overlap", 32'd1, 32'd0);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input logic spike);
        for (int i = 0; i < 16 * baud_div; i++) begin
            @(negedge clk);
            rx = (spike && i >= 30 && i < 34) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop, input int spike_bit);
        drive_bit(1'b0, 1'b0);
        for (int b = 0; b < 8; b++) drive_bit(data[b], b == spike_bit);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, 1'b0);
`endif
        drive_bit(stop, 1'b0);
    endtask

    task automatic idle_bits(input int n);
        for (int k = 0; k < n; k++) drive_bit(1'b1, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        send_frame(v.data, v.par, v.stop, v.spike_bit);
        idle_bits(2);
    endtask

    initial begin
        int d0, e0;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_done", 32'(uart_rx_done), 32'd0);
        checkOutput("reset_err", 32'(frame_err), 32'd0);
        checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset_busy", 32'(rx_busy), 32'd0);
        rst = 1'b0;
        idle_bits(1);

        vecs.push_back('{8'hA5, 1'b0, 1'b1, -1, 1, 0, 8'hA5});
        vecs.push_back('{8'h00, 1'b0, 1'b1, -1, 1, 0, 8'h00});
        vecs.push_back('{8'hFF, 1'b0, 1'b1, -1, 1, 0, 8'hFF});
        vecs.push_back('{8'h3C, 1'b0, 1'b1,  2, 1, 0, 8'h3C});
        vecs.push_back('{8'h12, 1'b0, 1'b0, -1, 0, 1, 8'h3C});
        vecs.push_back('{8'h55, 1'b0, 1'b1, -1, 1, 0, 8'h55});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, -1, 1, 0, 8'h07});
        vecs.push_back('{8'h07, 1'b0, 1'b1, -1, 0, 1, 8'h07});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
            checkOutput($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            checkOutput($sformatf("vec%0d_busy", i), 32'(rx_busy), 32'd0);
            model_rx = vecs[i].exp_rx;
        end

        // Back-to-back frames with a single stop bit.
        d0 = done_cnt;
        done_log.delete();
        send_frame(8'h00, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        idle_bits(2);
        checkOutput("b2b_done", 32'(done_cnt - d0), 32'd2);
        checkOutput("b2b_first", 32'(done_log.size() > 0 ? done_log[0] : 8'hEE), 32'h00);
        checkOutput("b2b_second", 32'(done_log.size() > 1 ? done_log[1] : 8'hEE), 32'hFF);
        model_rx = 8'hFF;

        // Short glitch on an idle line is a false start.
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        @(negedge clk);
        rx = 1'b1;
        checkOutput("glitch_busy_start", 32'(rx_busy), 32'd1);
        idle_bits(2);
        checkOutput("glitch_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("glitch_err", 32'(err_cnt - e0), 32'd0);
        checkOutput("glitch_busy_end", 32'(rx_busy), 32'd0);

        // Bad stop bit followed by a long break, then a clean frame.
        d0 = done_cnt;
        e0 = err_cnt;
        for (int k = 0; k < 41; k++) drive_bit(1'b0, 1'b0);
        idle_bits(2);
        checkOutput("break_err", 32'(err_cnt - e0), 32'd1);
        checkOutput("break_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("break_rx_data", 32'(rx_data), 32'(model_rx));
        send_frame(8'h55, 1'b0, 1'b1, -1);
        idle_bits(2);
        checkOutput("after_break_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("after_break_rx_data", 32'(rx_data), 32'h55);

        // baud_pulse held high: one tick per clk.
        baud_div = 1;
        d0 = done_cnt;
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        idle_bits(2);
        checkOutput("cont_baud_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("cont_baud_rx_data", 32'(rx_data), 32'h5A);
        baud_div = 4;
        idle_bits(1);

        // Reset in the middle of the data bits aborts the frame silently.
        d0 = done_cnt;
        e0 = err_cnt;
        drive_bit(1'b0, 1'b0);
        for (int b = 0; b < 3; b++) drive_bit(1'b1, 1'b0);
        repeat (32) @(negedge clk);
        checkOutput("mid_frame_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_done", 32'(uart_rx_done), 32'd0);
        checkOutput("mid_rst_err", 32'(frame_err), 32'd0);
        checkOutput("mid_rst_rx_data", 32'(rx_data), 32'd0);
        checkOutput("mid_rst_busy", 32'(rx_busy), 32'd0);
        rst = 1'b0;
        idle_bits(12);
        checkOutput("mid_rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1, -1);
        idle_bits(2);
        checkOutput("post_rst_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("post_rst_rx_data", 32'(rx_data), 32'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampler.md
Name: uart_rx_oversampler

Overview:
- Serial receive front end feeding the UART core's RX FIFO. Oversamples the asynchronous rx line at 16x the bit rate and recovers 8N1 frames with 3-sample majority voting.
- Pushes each good byte to the RX FIFO via a one-cycle done pulse.
- Reports framing errors and recovers cleanly from line breaks.
- baud_pulse comes from the core's divisor; it is a 16x oversample tick.

Parameters:
- DATA_BITS, 8, data bits per frame. Legal range 5..8; LSB received first.
- SYNC_STAGES, 2, flops in the rx metastability synchronizer. Minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- baud_pulse  in  1  16x oversample tick, one clk wide
- rx  in  1  asynchronous serial input; idle high
- uart_rx_done  out  1  one-cycle pulse; rx_data valid in the same cycle
- rx_data  out  DATA_BITS  last received byte; held until the next uart_rx_done
- frame_err  out  1  one-cycle pulse on bad stop bit (or bad parity, see Optional Feature)
- rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: synchronizer flops = 1, state = IDLE, tick_cnt = 0, bit_cnt = 0, shift reg = 0, rx_data = 0, uart_rx_done = 0, frame_err = 0, rx_busy = 0.
- rst mid-frame aborts the frame immediately. No done or error pulse is produced.
- All state, counters and sampling advance only on clk edges where baud_pulse = 1. The output pulses are registered.
- tick_cnt (4-bit) counts 0..15 within each bit period and wraps 15->0 at each bit boundary.
- At ticks 7, 8 and 9 the synchronized rx is captured. bit_val = majority of the 3 samples.
- States:
  - IDLE: if synced rx = 0 on a baud_pulse, go to START with tick_cnt = 0.
  - START: at tick 9, if bit_val = 1 (false start / glitch) return to IDLE with no pulse. At tick 15 go to DATA with bit_cnt = 0.
  - DATA: at tick 15 shift bit_val into the MSB of the shift reg (right shift, LSB first) and increment bit_cnt. After bit DATA_BITS-1, go to PARITY if the feature is enabled, else STOP.
  - STOP: evaluated at tick 9 (early exit, so back-to-back frames with 1 stop bit are not lost).
    - bit_val = 1: rx_data <= shift reg, pulse uart_rx_done next cycle, go to IDLE.
    - bit_val = 0: pulse frame_err, rx_data unchanged, no done pulse, go to BREAK.
  - BREAK: wait until synced rx = 1 on a baud_pulse, then go to IDLE. A continuous-low break therefore yields exactly one frame_err.
- Latency: uart_rx_done asserts 1 clk after the baud_pulse at stop-bit tick 9.
- uart_rx_done and frame_err are never high together. Each is exactly 1 clk wide regardless of baud_pulse spacing.
- No backpressure. The consumer must accept the byte in the pulse cycle; an overrun is the FIFO's concern.
- baud_pulse held high continuously is legal: one tick per clk.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled like a data bit and left at tick 15.
  - Even parity: the XOR of the data bits and the parity bit must be 0.
  - On mismatch, finish the stop bit normally, then pulse frame_err instead of uart_rx_done and leave rx_data unchanged.
  - A bad stop bit still routes to BREAK.
- Undefined: no PARITY state, no parity logic; the frame is strict 8N1.

Test Plan:
- baud_pulse every 4 clk; send 0xA5 as 8N1, 64 clk per bit -> one uart_rx_done, rx_data = 0xA5, frame_err never high, rx_busy low afterward.
- Send 0x00 then 0xFF back-to-back, stop bit 1 bit long -> two done pulses with rx_data 0x00 then 0xFF; no frame lost.
- 20-clk low glitch on idle line (under half a bit) -> no uart_rx_done, no frame_err, return to IDLE.
- 0x3C with a single-tick inverted spike at tick 8 of bit 2 -> majority vote rejects it; rx_data = 0x3C.
- Stop bit forced low, then line held low for 30 bit times, then high -> exactly one frame_err pulse, rx_data keeps its prior value, next frame 0x55 received correctly.
- UART_RX_PARITY_EN: 0x07 with parity bit 1 -> done, rx_data = 0x07. 0x07 with parity bit 0 -> frame_err only.
- Assert rst mid-DATA -> all outputs 0 next cycle. A subsequent 0x81 frame is received correctly.
